// File: rtl/taskwait_tracker_if.sv
// Event-in / ack-out handshake bundle for taskwait_tracker.
// The slave side is the tracker itself; the master side is the arbiter and ack sink.
interface taskwait_tracker_if #(
  parameter int ACC_BITS    = 4,
  parameter int TASKID_BITS = 64,
  parameter int COMP_BITS   = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_type;
  logic [TASKID_BITS-1:0] in_task_id;
  logic [ACC_BITS-1:0]    in_acc_id;
  logic [COMP_BITS-1:0]   in_components;

  logic                   out_valid;
  logic                   out_ready;
  logic [ACC_BITS-1:0]    out_acc_id;
  logic [TASKID_BITS-1:0] out_task_id;
  logic [7:0]             out_code;

  modport master (
    output in_valid, in_type, in_task_id, in_acc_id, in_components, out_ready,
    input  in_ready, out_valid, out_acc_id, out_task_id, out_code
  );

  modport slave (
    input  in_valid, in_type, in_task_id, in_acc_id, in_components, out_ready,
    output in_ready, out_valid, out_acc_id, out_task_id, out_code
  );
endinterface

// File: rtl/taskwait_tracker.sv
// Tracks outstanding child completions per parent task and acks the waiting
// accelerator once the signed pending count of a task that has been waited on reaches zero.
module taskwait_tracker #(
  parameter int TW_MEM_SIZE = 16,
  parameter int ACC_BITS    = 4,
  parameter int TASKID_BITS = 64,
  parameter int COMP_BITS   = 32
) (
  input  logic                              clk,
  input  logic                              rstn,
  taskwait_tracker_if.slave                 tw,
  output logic [$clog2(TW_MEM_SIZE+1)-1:0]  occupancy,
  output logic                              overflow
);

  localparam int IDX_BITS = $clog2(TW_MEM_SIZE);
  localparam int OCC_BITS = $clog2(TW_MEM_SIZE+1);
  localparam int CNT_BITS = COMP_BITS + 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOOKUP = 2'd1;
  localparam logic [1:0] UPDATE = 2'd2;
  localparam logic [1:0] ACK    = 2'd3;

  logic [1:0]             state;
  logic                   started;

  logic                   lat_type;
  logic [TASKID_BITS-1:0] lat_task_id;
  logic [ACC_BITS-1:0]    lat_acc_id;
  logic [COMP_BITS-1:0]   lat_components;

  logic [TW_MEM_SIZE-1:0] ent_valid;
  logic [TW_MEM_SIZE-1:0] ent_req_seen;
  logic [ACC_BITS-1:0]    ent_acc_id  [TW_MEM_SIZE];
  logic [TASKID_BITS-1:0] ent_task_id [TW_MEM_SIZE];
  logic [CNT_BITS-1:0]    ent_count   [TW_MEM_SIZE];

  logic                   lk_hit, lk_no_free;
  logic [IDX_BITS-1:0]    lk_hit_idx, lk_free_idx;
  logic                   hit, no_free;
  logic [IDX_BITS-1:0]    hit_idx, free_idx;

  logic [CNT_BITS-1:0]    base, new_count;
  logic                   is_zero, do_ack, do_free, do_write, do_alloc, do_drop;
  logic [IDX_BITS-1:0]    wr_idx;
  logic [ACC_BITS-1:0]    ack_acc;

  // started keeps in_ready low until the first clock edge after reset release
  assign tw.in_ready = (state == IDLE) && started;
  assign tw.out_code = 8'h01;

  // Descending scan so the lowest-index free slot wins; task IDs are unique in the table
  always_comb begin
    lk_hit      = 1'b0;
    lk_hit_idx  = '0;
    lk_no_free  = 1'b1;
    lk_free_idx = '0;
    for (int i = TW_MEM_SIZE - 1; i >= 0; i--) begin
      if (ent_valid[i] && (ent_task_id[i] == lat_task_id)) begin
        lk_hit     = 1'b1;
        lk_hit_idx = IDX_BITS'(i);
      end
      if (!ent_valid[i]) begin
        lk_no_free  = 1'b0;
        lk_free_idx = IDX_BITS'(i);
      end
    end
  end

  always_comb begin
    base      = hit ? ent_count[hit_idx] : '0;
    new_count = lat_type ? (base + {1'b0, lat_components})
                         : (base - {1'b0, lat_components});
    is_zero   = (new_count == '0);
    do_ack    = is_zero && (lat_type || (hit && ent_req_seen[hit_idx]));
    do_free   = is_zero && hit;
    do_write  = !is_zero && hit;
    do_alloc  = !is_zero && !hit && !no_free;
    do_drop   = !is_zero && !hit && no_free;
    wr_idx    = hit ? hit_idx : free_idx;
    ack_acc   = lat_type ? lat_acc_id : ent_acc_id[hit_idx];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state          <= IDLE;
      started        <= 1'b0;
      lat_type       <= 1'b0;
      lat_task_id    <= '0;
      lat_acc_id     <= '0;
      lat_components <= '0;
      hit            <= 1'b0;
      hit_idx        <= '0;
      no_free        <= 1'b0;
      free_idx       <= '0;
      ent_valid      <= '0;
      ent_req_seen   <= '0;
      occupancy      <= '0;
      overflow       <= 1'b0;
      tw.out_valid   <= 1'b0;
      tw.out_acc_id  <= '0;
      tw.out_task_id <= '0;
    end else begin
      started <= 1'b1;
      case (state)
        IDLE: begin
          if (tw.in_valid && started) begin
            lat_type       <= tw.in_type;
            lat_task_id    <= tw.in_task_id;
            lat_acc_id     <= tw.in_acc_id;
            lat_components <= tw.in_components;
            state          <= LOOKUP;
          end
        end
        LOOKUP: begin
          hit      <= lk_hit;
          hit_idx  <= lk_hit_idx;
          no_free  <= lk_no_free;
          free_idx <= lk_free_idx;
          state    <= UPDATE;
        end
        UPDATE: begin
          if (do_free) begin
            ent_valid[hit_idx]    <= 1'b0;
            ent_req_seen[hit_idx] <= 1'b0;
            occupancy             <= occupancy - OCC_BITS'(1);
          end else if (do_write || do_alloc) begin
            ent_valid[wr_idx] <= 1'b1;
            if (lat_type)
              ent_req_seen[wr_idx] <= 1'b1;
            else if (do_alloc)
              ent_req_seen[wr_idx] <= 1'b0;
            if (do_alloc)
              occupancy <= occupancy + OCC_BITS'(1);
          end
          if (do_drop)
            overflow <= 1'b1;
          if (do_ack) begin
            tw.out_valid   <= 1'b1;
            tw.out_acc_id  <= ack_acc;
            tw.out_task_id <= lat_task_id;
            state          <= ACK;
          end else begin
            state <= IDLE;
          end
        end
        ACK: begin
          if (tw.out_ready) begin
            tw.out_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Payload storage carries no reset; ent_valid alone decides whether a slot is live
  always_ff @(posedge clk) begin
    if ((state == UPDATE) && (do_write || do_alloc)) begin
      ent_count[wr_idx]   <= new_count;
      ent_task_id[wr_idx] <= lat_task_id;
      if (lat_type)
        ent_acc_id[wr_idx] <= lat_acc_id;
    end
  end

endmodule
